// File: rtl/bcd_filter_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_filter_seq_pkg
// Description : Shared definitions for the BCD filter sequencer: FSM state
//               encodings, the largest legal BCD digit and a digit-validity
//               helper used by the filter datapath.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_filter_seq_pkg;

  // Sequencer states; encodings are fixed so they can be probed externally.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Largest digit value that is legal BCD.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // True when a nibble holds a legal BCD digit (0..9).
  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage : bcd_filter_seq_pkg
`default_nettype wire

// File: rtl/bcd_filter_seq_filterbcd.sv
`default_nettype none
// ============================================================================
// Module      : filterBCD
// Description : Combinational single-digit BCD filter. Legal digits (0..9)
//               pass through unchanged; illegal nibbles (10..15) are replaced
//               by zero and flagged.
// Ports       : digit_in  [3:0] - raw nibble
//               digit_out [3:0] - filtered digit
//               error           - high when digit_in was not legal BCD
// Revision    : 1.0 - initial release
// ============================================================================
module filterBCD
  import bcd_filter_seq_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out,
  output logic       error
);

  logic w_legal;

  assign w_legal   = is_bcd(digit_in);
  assign digit_out = w_legal ? digit_in : 4'd0;
  assign error     = ~w_legal;

endmodule : filterBCD
`default_nettype wire

// File: rtl/bcd_filter_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd_filter_seq
// Description : Accepts a packed-BCD word on a valid/ready port, walks its
//               digits least-significant first through one shared filterBCD
//               instance (one digit per cycle), collects the filtered digits
//               plus a per-digit error mask/count, and presents the result on
//               a valid/ready output port.
// Ports       : clk, rst_n            - clock, async active-low reset
//               in_valid / in_ready   - input handshake
//               in_word   [4*DIGITS]  - packed BCD word, digit i at [4i+3:4i]
//               out_valid / out_ready - output handshake
//               out_word  [4*DIGITS]  - filtered digits, same packing
//               err_mask  [DIGITS]    - bit i set when digit i was > 9
//               err_count [CW]        - number of set bits in err_mask
//               err_any               - OR of err_mask
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_filter_seq
  import bcd_filter_seq_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CW     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_word,
  output logic [DIGITS-1:0]     err_mask,
  output logic [CW-1:0]         err_count,
  output logic                  err_any
);

  localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t                r_state;
  logic [4*DIGITS-1:0]   r_shift;
  logic [CW-1:0]         r_idx;

  logic [3:0]            w_f_digit;
  logic                  w_f_err;

  // The shared filter always looks at the bottom nibble of the shift
  // register; the register shifts right each SCAN cycle to feed it.
  filterBCD u_filter (
    .digit_in  (r_shift[3:0]),
    .digit_out (w_f_digit),
    .error     (w_f_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_idx     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_word  <= '0;
      err_mask  <= '0;
      err_count <= '0;
      err_any   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_shift   <= in_word;
            r_idx     <= '0;
            out_word  <= '0;
            err_mask  <= '0;
            err_count <= '0;
            err_any   <= 1'b0;
            in_ready  <= 1'b0;
            r_state   <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          // Steer the filter result into the slot selected by the index.
          for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == CW'(i)) begin
              out_word[4*i +: 4] <= w_f_digit;
              err_mask[i]        <= w_f_err;
            end
          end
          if (w_f_err) begin
            err_count <= err_count + ONE;
          end
          // Running OR keeps err_any registered and equal to |err_mask.
          err_any <= err_any | w_f_err;
          r_shift <= r_shift >> 4;
          r_idx   <= r_idx + ONE;
          if (r_idx == LAST_IDX) begin
            out_valid <= 1'b1;
            r_state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Result registers are untouched here, so they hold while stalled.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : bcd_filter_seq
`default_nettype wire

// File: tb/tb_bcd_filter_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_filter_seq
// Description : Directed self-checking bench for bcd_filter_seq (DIGITS=4,
//               plus a DIGITS=1 instance for the single-digit case).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_filter_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_word, out_word;
  logic [3:0]  err_mask;
  logic [2:0]  err_count;
  logic        err_any;

  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [3:0]  in_word1, out_word1;
  logic [0:0]  err_mask1;
  logic [0:0]  err_count1;
  logic        err_any1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_filter_seq #(.DIGITS(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .err_mask(err_mask), .err_count(err_count), .err_any(err_any)
  );

  bcd_filter_seq #(.DIGITS(1), .CW(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_word(in_word1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_word(out_word1),
    .err_mask(err_mask1), .err_count(err_count1), .err_any(err_any1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word, check latency, result, then complete the handshake.
  task automatic run_word(input string tag, input logic [15:0] word,
                          input logic [15:0] exp_word, input logic [3:0] exp_mask,
                          input logic [2:0] exp_cnt, input logic exp_any);
    int n;
    check({tag, " in_ready before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_word  = word;
    tick();                      // accept edge
    in_valid = 1'b0;
    in_word  = ~word;            // later changes must not matter
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd4);
    check({tag, " out_word"}, 32'(out_word), 32'(exp_word));
    check({tag, " err_mask"}, 32'(err_mask), 32'(exp_mask));
    check({tag, " err_count"}, 32'(err_count), 32'(exp_cnt));
    check({tag, " err_any"}, 32'(err_any), 32'(exp_any));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid after hs"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after hs"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int seen_valid;
    int cyc, rise0, rise1, nrise;
    logic prev_ov;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_word = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; in_word1 = '0;
    #12;
    // 1. reset / idle
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_word", 32'(out_word), 32'd0);
    check("rst err_mask", 32'(err_mask), 32'd0);
    check("rst err_count", 32'(err_count), 32'd0);
    check("rst err_any", 32'(err_any), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle in_ready", 32'(in_ready), 32'd1);
    check("idle out_valid", 32'(out_valid), 32'd0);

    // 2-4. main function
    run_word("w1234", 16'h1234, 16'h1234, 4'b0000, 3'd0, 1'b0);
    run_word("w9A0F", 16'h9A0F, 16'h9000, 4'b0101, 3'd2, 1'b1);
    run_word("wFFFF", 16'hFFFF, 16'h0000, 4'b1111, 3'd4, 1'b1);

    // 5. backpressure on 0987
    in_valid = 1'b1;
    in_word  = 16'h0987;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp latency", 32'(n), 32'd4);
    in_valid = 1'b1;             // must be ignored while busy
    in_word  = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp out_valid held", 32'(out_valid), 32'd1);
      check("bp out_word held", 32'(out_word), 32'h0987);
      check("bp err_mask held", 32'(err_mask), 32'd0);
      check("bp in_ready low", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp out_valid after hs", 32'(out_valid), 32'd0);
    check("bp in_ready after hs", 32'(in_ready), 32'd1);
    tick();
    check("bp ignored word", 32'(out_word), 32'h0987);
    check("bp still idle", 32'(in_ready), 32'd1);

    // 6. reset during the second SCAN cycle of 5B21
    in_valid = 1'b1;
    in_word  = 16'h5B21;
    tick();                      // accept edge
    in_valid = 1'b0;
    tick();                      // first SCAN edge: digit 0 written
    check("mid pre-reset out_word", 32'(out_word), 32'h0001);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst out_word", 32'(out_word), 32'd0);
    check("mid rst err_mask", 32'(err_mask), 32'd0);
    check("mid rst in_ready", 32'(in_ready), 32'd1);
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) seen_valid++;
    end
    check("mid no out_valid", 32'(seen_valid), 32'd0);
    run_word("w0042", 16'h0042, 16'h0042, 4'b0000, 3'd0, 1'b0);

    // Back-to-back throughput
    in_valid  = 1'b1;
    in_word   = 16'h0042;
    out_ready = 1'b1;
    cyc = 0; nrise = 0; rise0 = 0; rise1 = 0; prev_ov = out_valid;
    while (nrise < 2 && cyc < 40) begin
      tick();
      cyc++;
      if (out_valid && !prev_ov) begin
        if (nrise == 0) rise0 = cyc; else rise1 = cyc;
        nrise++;
      end
      prev_ov = out_valid;
    end
    in_valid  = 1'b0;
    check("b2b rises seen", 32'(nrise), 32'd2);
    check("b2b period", 32'(rise1 - rise0), 32'd6);
    tick();
    tick();
    out_ready = 1'b0;

    // DIGITS=1 instance
    in_valid1 = 1'b1;
    in_word1  = 4'hC;
    tick();
    in_valid1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 20) begin
      tick();
      n++;
    end
    check("d1 latency", 32'(n), 32'd1);
    check("d1 out_word C", 32'(out_word1), 32'd0);
    check("d1 err_mask C", 32'(err_mask1), 32'd1);
    check("d1 err_count C", 32'(err_count1), 32'd1);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    in_valid1  = 1'b1;
    in_word1   = 4'h7;
    tick();
    in_valid1 = 1'b0;
    tick();
    check("d1 out_valid 7", 32'(out_valid1), 32'd1);
    check("d1 out_word 7", 32'(out_word1), 32'h7);
    check("d1 err_any 7", 32'(err_any1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bcd_filter_seq
`default_nettype wire
